spi_master_20mhz: RTL and testbench
===================================

Name: spi_master_20mhz

Overview:
Single-clock SPI master in the 100 MHz system domain. It consumes the divide-by-5 serial-clock timing (20 MHz SCLK) from the system clock and serialises one DATA_W-bit word per transaction. It generates SCLK, CS_N and MOSI and captures MISO at the same time (full duplex). Mode 0 only (CPOL=0, CPHA=0), MSB first. It sits between the register/command logic, which uses a valid/ready handshake, and the off-chip SPI pins.

Parameters:
DATA_W, 16, bits per transaction (must be >= 1)
CLK_DIV, 5, system clocks per SCLK period (must be >= 2); 5 gives 20 MHz from 100 MHz
CS_LEAD, 2, system clocks with CS_N low before the first SCLK period (must be >= 1)
CS_TRAIL, 2, system clocks with CS_N low after the last SCLK period (must be >= 1)

Ports:
clk  in  1  system clock, 100 MHz
rst  in  1  synchronous reset, active-high
tx_data  in  DATA_W  word to transmit; sampled on acceptance
tx_valid  in  1  request to start a transaction
tx_ready  out  1  high only in IDLE; a transaction is accepted when tx_valid && tx_ready at a rising clk edge
rx_data  out  DATA_W  last received word; holds until the next rx_valid
rx_valid  out  1  one-cycle pulse when rx_data updates
busy  out  1  high when state != IDLE
sclk  out  1  SPI clock, registered, idles low
cs_n  out  1  chip select, active-low, registered
mosi  out  1  serial data out, registered
miso  in  1  serial data in

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state IDLE, sclk=0, cs_n=1, mosi=0, rx_valid=0, rx_data=0, busy=0, tx_ready=1 (combinational from state; it is low while rst is high).
- FSM states: IDLE -> LEAD -> SHIFT -> TRAIL -> IDLE.
- IDLE:
  - Accept on tx_valid && tx_ready.
  - At that edge: latch tx_data into the shift register, cs_n<=0, mosi<=tx_data[DATA_W-1], go to LEAD.
  - tx_valid is ignored in every other state.
- LEAD: lasts CS_LEAD cycles; sclk=0.
- SHIFT:
  - Runs DATA_W periods of CLK_DIV cycles each.
  - A phase counter runs 0..CLK_DIV-1 and is $clog2(CLK_DIV) bits wide.
  - LOW_CNT = CLK_DIV/2, integer floor.
  - sclk=0 for phases 0..LOW_CNT-1 and sclk=1 for phases LOW_CNT..CLK_DIV-1. For CLK_DIV=5 this is 2 cycles low, 3 cycles high.
- MISO sampling: at the edge where sclk goes 0->1, the current miso is shifted into the receive register LSB, so data arrives MSB first.
- MOSI update:
  - At the edge where the phase wraps CLK_DIV-1 -> 0 (sclk falls), mosi advances to the next lower bit.
  - After the final period, mosi holds bit 0 through TRAIL.
  - mosi returns to 0 in IDLE.
- Bit counter: counts completed periods. After period DATA_W, sclk<=0 and the FSM goes to TRAIL.
- TRAIL: lasts CS_TRAIL cycles with cs_n=0 and sclk=0. At its last edge: cs_n<=1, rx_data<=receive register, rx_valid<=1, go to IDLE.
- Timing with defaults, counting the acceptance cycle as 0:
  - cs_n low in cycles 1..84: LEAD 1-2, SHIFT 3-82, TRAIL 83-84.
  - rx_valid high in cycle 85.
  - Exactly 16 sclk rising edges per transaction.
  - General latency: 1 + CS_LEAD + DATA_W*CLK_DIV + CS_TRAIL.
- Back-to-back: tx_ready is high in the rx_valid cycle. If tx_valid is held, the next transaction is accepted there, so cs_n is high for exactly 1 cycle between transactions. No data is lost.
- Reset mid-operation: the next edge forces the reset values and a return to IDLE. No rx_valid pulse is produced; rx_data is cleared to 0. Any partial word is discarded.
- Glitch rule: sclk never toggles outside SHIFT, and cs_n never changes while sclk=1.

Test Plan:
- Reset: hold rst 3 cycles in mid-SHIFT -> cs_n=1, sclk=0, mosi=0, rx_valid=0, rx_data=0x0000, tx_ready=1 in the first cycle after rst deasserts.
- Loopback (mosi->miso), send 0xA5C3 -> rx_data=0xA5C3 with rx_valid pulse in cycle 85 after acceptance; 16 sclk rises; each period 2 cycles low, 3 cycles high; cs_n low exactly cycles 1..84.
- miso tied 1, tx_data=0x0000 -> mosi=0 throughout, rx_data=0xFFFF; then miso tied 0, tx_data=0xFFFF -> mosi=1 for the whole SHIFT phase, rx_data=0x0000.
- Back-to-back: tx_valid held high with 0x1234 then 0xBEEF under loopback -> two rx_valid pulses 85 cycles apart carrying 0x1234 then 0xBEEF; cs_n high for exactly 1 cycle between them.
- Busy ignore: pulse tx_valid with 0x5555 at cycle 40 of an active 0x00FF transfer -> no effect; rx_data=0x00FF, and no second transaction starts.
- Parameter variant CLK_DIV=2, DATA_W=8, loopback 0x81 -> sclk 1 cycle low, 1 cycle high; rx_data=0x81 with rx_valid in cycle 1+2+16+2=21.

Source files
------------

// File: rtl/spi_master_20mhz.sv
`default_nettype none
// ============================================================================
// Module   : spi_master_20mhz
// Brief    : Mode-0, MSB-first, full-duplex SPI master with a valid/ready
//            command side and registered SCLK / CS_N / MOSI pins.
// Revision : 1.0 - initial release
// ============================================================================
module spi_master_20mhz #(
    parameter int DATA_W   = 16,
    parameter int CLK_DIV  = 5,
    parameter int CS_LEAD  = 2,
    parameter int CS_TRAIL = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              busy,
    output logic              sclk,
    output logic              cs_n,
    output logic              mosi,
    input  logic              miso
);

    localparam int c_PH_W     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int c_BIT_W    = $clog2(DATA_W + 1);
    localparam int c_HOLD_MAX = (CS_LEAD > CS_TRAIL) ? CS_LEAD : CS_TRAIL;
    localparam int c_HOLD_W   = (c_HOLD_MAX > 1) ? $clog2(c_HOLD_MAX) : 1;

    localparam logic [c_PH_W-1:0]   c_PH_LAST    = c_PH_W'(CLK_DIV - 1);
    localparam logic [c_PH_W-1:0]   c_LOW_CNT    = c_PH_W'(CLK_DIV / 2);
    localparam logic [c_PH_W-1:0]   c_PH_RISE    = c_PH_W'(CLK_DIV / 2 - 1);
    localparam logic [c_BIT_W-1:0]  c_BIT_LAST   = c_BIT_W'(DATA_W - 1);
    localparam logic [c_HOLD_W-1:0] c_LEAD_LAST  = c_HOLD_W'(CS_LEAD - 1);
    localparam logic [c_HOLD_W-1:0] c_TRAIL_LAST = c_HOLD_W'(CS_TRAIL - 1);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_LEAD  = 2'd1;
    localparam logic [1:0] c_SHIFT = 2'd2;
    localparam logic [1:0] c_TRAIL = 2'd3;

    logic [1:0]          r_state;
    logic [1:0]          w_state_nxt;
    logic [c_HOLD_W-1:0] r_hold;
    logic [c_PH_W-1:0]   r_phase;
    logic [c_PH_W-1:0]   w_phase_nxt;
    logic [c_BIT_W-1:0]  r_bit;
    logic [DATA_W-1:0]   r_tx;
    logic [DATA_W-1:0]   r_rx;
    logic [DATA_W-1:0]   w_tx_shl;
    logic                w_accept;
    logic                w_lead_done;
    logic                w_trail_done;
    logic                w_wrap;
    logic                w_rise;
    logic                w_last_bit;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE:  if (w_accept)     w_state_nxt = c_LEAD;
            c_LEAD:  if (w_lead_done)  w_state_nxt = c_SHIFT;
            c_SHIFT: if (w_last_bit)   w_state_nxt = c_TRAIL;
            c_TRAIL: if (w_trail_done) w_state_nxt = c_IDLE;
            default:                   w_state_nxt = c_IDLE;
        endcase
    end

    // Handshake outputs and per-cycle event decode shared by the FSM and datapath.
    always_comb begin
        tx_ready     = (r_state == c_IDLE) && !rst;
        busy         = (r_state != c_IDLE);
        w_accept     = tx_valid && tx_ready;
        w_lead_done  = (r_state == c_LEAD)  && (r_hold == c_LEAD_LAST);
        w_trail_done = (r_state == c_TRAIL) && (r_hold == c_TRAIL_LAST);
        w_wrap       = (r_state == c_SHIFT) && (r_phase == c_PH_LAST);
        w_rise       = (r_state == c_SHIFT) && (r_phase == c_PH_RISE);
        w_last_bit   = w_wrap && (r_bit == c_BIT_LAST);
        w_phase_nxt  = (r_phase == c_PH_LAST) ? '0 : r_phase + 1'b1;
        w_tx_shl     = r_tx << 1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hold   <= '0;
            r_phase  <= '0;
            r_bit    <= '0;
            r_tx     <= '0;
            r_rx     <= '0;
            sclk     <= 1'b0;
            cs_n     <= 1'b1;
            mosi     <= 1'b0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (w_accept) begin
                        r_tx   <= tx_data;
                        cs_n   <= 1'b0;
                        mosi   <= tx_data[DATA_W-1];
                        r_hold <= '0;
                    end
                end
                c_LEAD: begin
                    r_hold <= r_hold + 1'b1;
                    if (w_lead_done) begin
                        r_phase <= '0;
                        r_bit   <= '0;
                    end
                end
                c_SHIFT: begin
                    // Phase 0 always maps to sclk low, so the final wrap parks sclk low too.
                    r_phase <= w_phase_nxt;
                    sclk    <= (w_phase_nxt >= c_LOW_CNT);
                    if (w_rise) begin
                        r_rx <= (r_rx << 1) | DATA_W'(miso);
                    end
                    if (w_wrap) begin
                        r_bit <= r_bit + 1'b1;
                        if (w_last_bit) begin
                            r_hold <= '0;
                        end else begin
                            r_tx <= w_tx_shl;
                            mosi <= w_tx_shl[DATA_W-1];
                        end
                    end
                end
                c_TRAIL: begin
                    r_hold <= r_hold + 1'b1;
                    if (w_trail_done) begin
                        cs_n     <= 1'b1;
                        mosi     <= 1'b0;
                        rx_data  <= r_rx;
                        rx_valid <= 1'b1;
                    end
                end
                default: begin
                    cs_n <= 1'b1;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_spi_master_20mhz.sv
`default_nettype none
// Testbench for spi_master_20mhz: scoreboard of expected words plus pin-level
// protocol monitor, with a second small-parameter instance.
module tb_spi_master_20mhz;

    localparam int DATA_W   = 16;
    localparam int CLK_DIV  = 5;
    localparam int CS_LEAD  = 2;
    localparam int CS_TRAIL = 2;
    localparam int LAT      = 1 + CS_LEAD + DATA_W * CLK_DIV + CS_TRAIL;
    localparam int V_W      = 8;
    localparam int V_DIV    = 2;
    localparam int V_LAT    = 1 + CS_LEAD + V_W * V_DIV + CS_TRAIL;

    typedef struct {
        logic [15:0] rx;
        logic [15:0] tx;
        int          acc;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [15:0] tx_data, rx_data;
    logic        tx_valid, tx_ready, rx_valid, busy, sclk, cs_n, mosi, miso;
    logic [7:0]  tx_data8, rx_data8;
    logic        tx_valid8, tx_ready8, rx_valid8, busy8, sclk8, cs_n8, mosi8, miso8;

    logic        loopback;
    logic        slave_bit;
    logic [15:0] slave_word, slave_sh;

    assign miso  = loopback ? mosi : slave_bit;
    assign miso8 = mosi8;

    spi_master_20mhz #(.DATA_W(DATA_W), .CLK_DIV(CLK_DIV), .CS_LEAD(CS_LEAD), .CS_TRAIL(CS_TRAIL)) u_dut (
        .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy), .sclk(sclk), .cs_n(cs_n),
        .mosi(mosi), .miso(miso)
    );

    spi_master_20mhz #(.DATA_W(V_W), .CLK_DIV(V_DIV), .CS_LEAD(CS_LEAD), .CS_TRAIL(CS_TRAIL)) u_dut8 (
        .clk(clk), .rst(rst), .tx_data(tx_data8), .tx_valid(tx_valid8), .tx_ready(tx_ready8),
        .rx_data(rx_data8), .rx_valid(rx_valid8), .busy(busy8), .sclk(sclk8), .cs_n(cs_n8),
        .mosi(mosi8), .miso(miso8)
    );

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    exp_t q[$];
    exp_t q8[$];
    int   cs_gap   = 0;
    int   rxv_prev = 0;
    int   rxv_last = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual 0x%0h required 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Mode-0 slave: presents MSB on CS_N fall, next bit after each SCLK fall.
    initial begin
        logic s_pc, s_ps;
        s_pc = 1'b1; s_ps = 1'b0; slave_bit = 1'b0; slave_sh = '0;
        forever begin
            @(negedge clk);
            if (!cs_n && s_pc) begin
                slave_bit = slave_word[15];
                slave_sh  = slave_word << 1;
            end else if (!cs_n && !sclk && s_ps) begin
                slave_bit = slave_sh[15];
                slave_sh  = slave_sh << 1;
            end
            s_pc = cs_n;
            s_ps = sclk;
        end
    end

    // Pin monitor and scoreboard for the default instance.
    initial begin
        logic        ps, pc;
        int          run, rises, cs_low, rise_cyc;
        logic [15:0] cap;
        exp_t        e;
        ps = 1'b0; pc = 1'b1; run = 0; rises = 0; cs_low = 0; rise_cyc = 0; cap = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                run = 0; rises = 0; cs_low = 0; cap = '0;
                check("tx_ready during reset", tx_ready, 0);
            end else begin
                check("busy vs cs_n", busy, !cs_n);
                check("tx_ready vs busy", tx_ready, !busy);
                if (cs_n != pc) begin
                    check("cs_n edge while sclk high", sclk | ps, 0);
                    if (!cs_n) begin
                        check("transaction pending at cs_n fall", q.size(), 1);
                        if (q.size() > 0) check("cs_n fall cycle", cyc - q[0].acc, 1);
                        cs_gap = cyc - rise_cyc;
                        rises = 0; cap = '0; run = 0; cs_low = 0;
                    end else begin
                        rise_cyc = cyc;
                    end
                end
                if (sclk != ps) begin
                    check("sclk toggle with cs_n high", cs_n, 0);
                    if (sclk) begin
                        rises++;
                        cap = {cap[14:0], mosi};
                        if (rises > 1) check("sclk low length", run, CLK_DIV / 2);
                    end else begin
                        check("sclk high length", run, CLK_DIV - CLK_DIV / 2);
                    end
                    run = 1;
                end else begin
                    run++;
                end
                if (!cs_n) cs_low++;
                else if (pc) check("idle sclk/mosi", {sclk, mosi}, 0);
                if (rx_valid) begin
                    check("rx_valid with word pending", q.size() > 0, 1);
                    if (q.size() > 0) begin
                        e = q.pop_front();
                        check("rx_data", rx_data, e.rx);
                        check("rx_valid latency", cyc - e.acc, LAT);
                        check("sclk rises", rises, DATA_W);
                        check("cs_n low cycles", cs_low, LAT - 1);
                        check("mosi word seen by slave", cap, e.tx);
                        rxv_prev = rxv_last;
                        rxv_last = cyc;
                    end
                end
            end
            ps = sclk;
            pc = cs_n;
        end
    end

    // Monitor for the small-parameter instance.
    initial begin
        logic ps8;
        int   run8, rises8;
        exp_t e8;
        ps8 = 1'b0; run8 = 0; rises8 = 0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (sclk8 != ps8) begin
                    check("v sclk toggle with cs_n high", cs_n8, 0);
                    if (sclk8) begin
                        rises8++;
                        if (rises8 > 1) check("v sclk low length", run8, V_DIV / 2);
                    end else begin
                        check("v sclk high length", run8, V_DIV - V_DIV / 2);
                    end
                    run8 = 1;
                end else begin
                    run8++;
                end
                if (rx_valid8) begin
                    check("v rx_valid with word pending", q8.size() > 0, 1);
                    if (q8.size() > 0) begin
                        e8 = q8.pop_front();
                        check("v rx_data", rx_data8, e8.rx);
                        check("v rx_valid latency", cyc - e8.acc, V_LAT);
                        check("v sclk rises", rises8, V_W);
                    end
                    rises8 = 0;
                end
            end
            ps8 = sclk8;
        end
    end

    task automatic send(input logic [15:0] d);
        int acc, t;
        bit rdy;
        @(negedge clk);
        tx_data = d; tx_valid = 1'b1; t = 0;
        rdy = tx_ready; acc = cyc;
        while (!rdy && t < 200) begin
            @(negedge clk);
            rdy = tx_ready; acc = cyc; t++;
        end
        @(posedge clk);
        check("tx_ready within bound", rdy, 1);
        if (rdy) q.push_back('{rx: (loopback ? d : slave_word), tx: d, acc: acc});
    endtask

    task automatic send8(input logic [7:0] d);
        int acc, t;
        bit rdy;
        @(negedge clk);
        tx_data8 = d; tx_valid8 = 1'b1; t = 0;
        rdy = tx_ready8; acc = cyc;
        while (!rdy && t < 200) begin
            @(negedge clk);
            rdy = tx_ready8; acc = cyc; t++;
        end
        @(posedge clk);
        check("v tx_ready within bound", rdy, 1);
        if (rdy) q8.push_back('{rx: {8'h00, d}, tx: {8'h00, d}, acc: acc});
        @(negedge clk);
        tx_valid8 = 1'b0;
    endtask

    task automatic drop_valid();
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic wait_done();
        int t;
        t = 0;
        while ((q.size() != 0 || q8.size() != 0) && t < 400) begin
            @(negedge clk);
            t++;
        end
        check("transaction completes in time", q.size() + q8.size(), 0);
        @(negedge clk);
    endtask

    task automatic check_reset_pins(input string tag);
        check({tag, " cs_n"}, cs_n, 1);
        check({tag, " sclk"}, sclk, 0);
        check({tag, " mosi"}, mosi, 0);
        check({tag, " rx_valid"}, rx_valid, 0);
        check({tag, " rx_data"}, rx_data, 16'h0000);
        check({tag, " tx_ready"}, tx_ready, 1);
        check({tag, " busy"}, busy, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, actual timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] d;
        rst = 1'b1; tx_valid = 1'b0; tx_data = '0; tx_valid8 = 1'b0; tx_data8 = '0;
        loopback = 1'b1; slave_word = '0;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_reset_pins("initial reset");

        send(16'hA5C3); drop_valid(); wait_done();

        loopback = 1'b0; slave_word = 16'hFFFF;
        send(16'h0000); drop_valid(); wait_done();
        slave_word = 16'h0000;
        send(16'hFFFF); drop_valid(); wait_done();

        loopback = 1'b1;
        send(16'h1234);
        send(16'hBEEF);
        drop_valid(); wait_done();
        check("cs_n high gap between back-to-back", cs_gap, 1);
        check("rx_valid spacing back-to-back", rxv_last - rxv_prev, LAT);

        send(16'h00FF); drop_valid();
        repeat (38) @(negedge clk);
        tx_data = 16'h5555; tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        wait_done();
        repeat (100) @(negedge clk);
        check("rx_data after ignored request", rx_data, 16'h00FF);

        send(16'h3C5A); drop_valid();
        repeat (40) @(negedge clk);
        rst = 1'b1;
        q.delete();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_reset_pins("mid-shift reset");
        repeat (100) @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            loopback   = 1'($urandom_range(0, 1));
            slave_word = 16'($urandom);
            d          = 16'($urandom);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            send(d); drop_valid(); wait_done();
        end

        send8(8'h81); wait_done();
        for (int i = 0; i < 3; i++) begin
            send8(8'($urandom)); wait_done();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
